// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO burst arbiter and related SoC arbiters.
package fifo_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // One MNIST image row; default burst length.
  localparam int MNIST_ROW_LEN = 28;

  // Increment an index, wrapping at n back to zero.
  function automatic int rr_wrap_inc(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int w_cand;

  // Scan offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = (int'(ptr) + i) % N;
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = IDW'(w_cand);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter granting one producer a fixed-length burst on a shared
// FIFO write port. Data path to the FIFO pins is combinational.
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = MNIST_ROW_LEN,
  parameter int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic                     busy,
  output logic                     burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_burst_done;

  logic                w_found;
  logic [ID_WIDTH-1:0] w_pick_idx;
  logic                w_in_burst;
  logic                w_beat;
  logic                w_last_beat;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  assign w_in_burst  = (r_state == ST_BURST);
  assign w_beat      = w_in_burst & req_valid[r_grant_id] & ~fifo_full;
  assign w_last_beat = w_beat & (r_beat_cnt == CNT_W'(BURST_LEN - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant on any request in IDLE, leave BURST on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, beat counter, round-robin pointer and burst_done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
      r_beat_cnt   <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= w_last_beat;
      if (!w_in_burst && w_found) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1'b1);
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
      if (w_last_beat) begin
        r_rr_ptr <= ID_WIDTH'(rr_wrap_inc(int'(r_grant_id), NUM_REQ));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // FIFO-side muxing: only the owner sees ready, only while FIFO has room.
  always_comb begin
    req_ready  = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    if (w_in_burst) begin
      req_ready[r_grant_id] = ~fifo_full;
      fifo_push             = w_beat;
      fifo_wdata            = req_data[int'(r_grant_id)*WIDTH +: WIDTH];
    end else begin
      req_ready  = '0;
      fifo_push  = 1'b0;
      fifo_wdata = '0;
    end
  end

  assign grant_id   = r_grant_id;
  assign busy       = w_in_burst;
  assign burst_done = r_burst_done;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Directed self-checking bench for fifo_burst_arbiter (NUM_REQ=4, WIDTH=32,
// BURST_LEN=28).
module tb_fifo_burst_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int BL = 28;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_push;
  logic [W-1:0]    fifo_wdata;
  logic [1:0]      grant_id;
  logic            busy;
  logic            burst_done;

  int checks;
  int failures;
  int cyc;

  fifo_burst_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer i drives {i+1, cycle count} so every word is distinct.
  function automatic logic [W-1:0] word_of(input int id, input int c);
    return {8'(id + 1), 24'(c)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NR; i++) begin
      req_data[i*W +: W] = word_of(i, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_data();
  endtask

  // Check all outputs mid-cycle, then advance one clock.
  task automatic expect_cycle(input string tag, input logic push, input logic [3:0] rdy,
                              input int gid, input logic bsy, input logic done);
    @(negedge clk);
    check_eq({tag, "_push"}, 64'(fifo_push), 64'(push));
    check_eq({tag, "_ready"}, 64'(req_ready), 64'(rdy));
    check_eq({tag, "_grant"}, 64'(grant_id), 64'(gid));
    check_eq({tag, "_busy"}, 64'(busy), 64'(bsy));
    check_eq({tag, "_done"}, 64'(burst_done), 64'(done));
    check_eq({tag, "_wdata"}, 64'(fifo_wdata), bsy ? 64'(word_of(gid, cyc)) : 64'h0);
    tick();
  endtask

  // n consecutive beats by owner id.
  task automatic beats(input string tag, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      expect_cycle(tag, 1'b1, 4'(1 << id), id, 1'b1, 1'b0);
    end
  endtask

  // One IDLE arbitration cycle followed by a full unstalled burst.
  task automatic do_burst(input string tag, input int id, input int prev_gid, input logic prev_done);
    expect_cycle({tag, "_idle"}, 1'b0, 4'b0000, prev_gid, 1'b0, prev_done);
    beats(tag, id, BL);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    reset     = 1'b1;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    drive_data();
    tick();
    expect_cycle("rst", 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    reset = 1'b0;

    // A: single requester, 28 pushes, done pulse, busy low.
    req_valid = 4'b0001;
    do_burst("A", 0, 0, 1'b0);
    req_valid = 4'b0000;
    expect_cycle("A_end", 1'b0, 4'b0000, 0, 1'b0, 1'b1);
    expect_cycle("A_quiet", 1'b0, 4'b0000, 0, 1'b0, 1'b0);

    // B: all request after reset -> 0,1,2,3,0 with one idle cycle between.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    do_burst("B0", 0, 0, 1'b0);
    do_burst("B1", 1, 0, 1'b1);
    do_burst("B2", 2, 1, 1'b1);
    do_burst("B3", 3, 2, 1'b1);
    do_burst("B4", 0, 3, 1'b1);
    req_valid = 4'b0000;
    expect_cycle("B_end", 1'b0, 4'b0000, 0, 1'b0, 1'b1);

    // C: move rr_ptr to 2 via a burst from 1, then 0011 wraps to 0 then 1.
    req_valid = 4'b0010;
    do_burst("C_pre", 1, 0, 1'b0);
    req_valid = 4'b0011;
    do_burst("C0", 0, 1, 1'b1);
    do_burst("C1", 1, 0, 1'b1);
    req_valid = 4'b0000;
    expect_cycle("C_end", 1'b0, 4'b0000, 1, 1'b0, 1'b1);

    // D: fifo_full for 5 cycles at beat 10; burst still totals 28 beats.
    req_valid = 4'b0001;
    do_burst("D_a", 0, 1, 1'b0);
    req_valid = 4'b0000;
    expect_cycle("D_a_end", 1'b0, 4'b0000, 0, 1'b0, 1'b1);
    req_valid = 4'b0001;
    expect_cycle("D_idle", 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    beats("D_pre", 0, 10);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_cycle("D_full", 1'b0, 4'b0000, 0, 1'b1, 1'b0);
    end
    fifo_full = 1'b0;
    beats("D_post", 0, 18);
    req_valid = 4'b0000;
    expect_cycle("D_end", 1'b0, 4'b0000, 0, 1'b0, 1'b1);

    // E: owner 1 drops valid 3 cycles mid-burst while others still request.
    req_valid = 4'b1111;
    expect_cycle("E_idle", 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    beats("E_pre", 1, 5);
    req_valid = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("E_drop", 1'b0, 4'b0010, 1, 1'b1, 1'b0);
    end
    req_valid = 4'b1111;
    beats("E_post", 1, 23);
    req_valid = 4'b0000;
    expect_cycle("E_end", 1'b0, 4'b0000, 1, 1'b0, 1'b1);

    // F: reset at beat 15 clears outputs at once; next grant starts from 0.
    req_valid = 4'b1111;
    expect_cycle("F_idle", 1'b0, 4'b0000, 1, 1'b0, 1'b0);
    beats("F_pre", 2, 15);
    reset = 1'b1;
    #1;
    check_eq("F_rst_push", 64'(fifo_push), 64'h0);
    check_eq("F_rst_busy", 64'(busy), 64'h0);
    check_eq("F_rst_ready", 64'(req_ready), 64'h0);
    check_eq("F_rst_grant", 64'(grant_id), 64'h0);
    expect_cycle("F_rst", 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    reset = 1'b0;
    do_burst("F_after", 0, 0, 1'b0);
    req_valid = 4'b0000;
    expect_cycle("F_end", 1'b0, 4'b0000, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
